dot_accumulator: RTL

Signed accumulate stage that sits directly downstream of the 8-bit signed multiplier. It sums a stream of 16-bit two's-complement products into a saturating ACC_W-bit accumulator and closes a frame when the last product is flagged. It then holds the frame's sum, product count and overflow flag behind a valid/ready handshake until the consumer takes them.

---
 rtl/dot_accumulator.sv | 96 +++++++++
 1 files changed

// File: rtl/dot_accumulator.sv
// rtl/dot_accumulator.sv - saturating signed product accumulator with framed valid/ready result
module dot_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      prod_in,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [ACC_W:0]   sum;

  assign accept = prod_valid & prod_ready;

  // One guard bit above the accumulator: the top two bits disagree exactly on overflow.
  assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-16){prod_in[15]}}, prod_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = prod_last ? DONE : ACCUM;
      ACCUM:   if (accept && prod_last) state_d = DONE;
      DONE:    if (acc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == DONE) begin
      if (acc_ready) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    end else if (accept) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Handshake outputs come straight from the state register, never from acc_ready.
  always_comb begin
    prod_ready = 1'b1;
    acc_valid  = 1'b0;
    if (state_q == DONE) begin
      prod_ready = 1'b0;
      acc_valid  = 1'b1;
    end
  end

  assign acc_out = acc_q;
  assign cnt_out = cnt_q;
  assign ovf     = ovf_q;

endmodule
